// File: rtl/yutorina_bus_if_pkg.sv
// Shared types and constants for the yutorina MEM-stage bus interface:
// state encodings, slave-select decode and word-level bus typedefs.
package yutorina_bus_if_pkg;

    localparam int WORD_ADDR_W  = 30;
    localparam int WORD_DATA_W  = 32;
    localparam int SPM_ADDR_LOC = 12;

    typedef logic [WORD_ADDR_W-1:0]  word_addr_t;
    typedef logic [WORD_DATA_W-1:0]  word_data_t;
    typedef logic [SPM_ADDR_LOC-1:0] spm_addr_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int       SLAVE_SEL_MSB = 29;
    localparam int       SLAVE_SEL_LSB = 27;
    localparam logic [2:0] SPM_SEL     = 3'h1;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_t;

    // Timeout counter width: just wide enough for the limit, kept within 8..16 bits.
    function automatic int unsigned timer_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/yutorina_bus_if_if.sv
// External shared-bus signal bundle; master is the CPU-side initiator,
// slave is the arbiter/target side.
interface yutorina_bus_if_if;
    import yutorina_bus_if_pkg::*;

    logic       bus_req_;
    logic       bus_grnt_;
    word_addr_t bus_addr;
    logic       bus_as_;
    logic       bus_rw;
    word_data_t bus_wr_data;
    word_data_t bus_rd_data;
    logic       bus_rdy_;
    logic       bus_err;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_err,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, bus_err,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/yutorina_bus_if_timer.sv
// ACCESS-phase timeout counter; only present when YUTORINA_BUS_IF_TIMEOUT_EN
// is defined, so the default build carries no counter logic at all.
`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
module yutorina_bus_if_timer
    import yutorina_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int unsigned CNT_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear)
            cnt_next = '0;
        else if (count)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign expired = count && (cnt_reg == LIMIT);
endmodule
`endif

// File: rtl/yutorina_bus_if.sv
// MEM-stage bus interface: zero-stall SPM accesses plus arbitrated external
// bus accesses. Optional ACCESS timeout under YUTORINA_BUS_IF_TIMEOUT_EN.
module yutorina_bus_if
    import yutorina_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    output logic       busy,
    input  word_addr_t addr,
    input  logic       as_,
    input  logic       rw,
    input  word_data_t wr_data,
    output word_data_t rd_data,
    output spm_addr_t  spm_addr,
    output logic       spm_as_,
    output logic       spm_rw,
    output word_data_t spm_wr_data,
    input  word_data_t spm_rd_data,
    yutorina_bus_if_if.master bus
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    bus_if_state_t state_reg, state_next;
    logic       bus_req_reg, bus_req_next;
    logic       bus_as_reg, bus_as_next;
    word_addr_t bus_addr_reg, bus_addr_next;
    logic       bus_rw_reg, bus_rw_next;
    word_data_t bus_wr_data_reg, bus_wr_data_next;
    word_data_t rd_buf_reg, rd_buf_next;
    logic       sel_spm_reg, sel_spm_next;
    logic       err_pulse;
    logic       req_valid, is_spm;

    assign req_valid = (as_ == ENABLE_) && !stall && !flush;
    assign is_spm    = (addr[SLAVE_SEL_MSB:SLAVE_SEL_LSB] == SPM_SEL);

`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
    logic timer_clear, timer_count, timer_expired;

    yutorina_bus_if_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (timer_expired)
    );
`endif

    always_comb begin
        state_next       = state_reg;
        bus_req_next     = bus_req_reg;
        bus_as_next      = bus_as_reg;
        bus_addr_next    = bus_addr_reg;
        bus_rw_next      = bus_rw_reg;
        bus_wr_data_next = bus_wr_data_reg;
        rd_buf_next      = rd_buf_reg;
        sel_spm_next     = 1'b0;
        busy             = 1'b0;
        err_pulse        = 1'b0;
        spm_as_          = DISABLE_;
        spm_addr         = addr[SPM_ADDR_LOC-1:0];
        spm_rw           = rw;
        spm_wr_data      = wr_data;
`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
        timer_clear      = 1'b0;
        timer_count      = 1'b0;
`endif
        case (state_reg)
            BUS_IF_STATE_IDLE: begin
                if (req_valid) begin
                    if (is_spm) begin
                        spm_as_      = ENABLE_;
                        sel_spm_next = (rw == READ);
                    end else begin
                        busy             = 1'b1;
                        bus_req_next     = ENABLE_;
                        bus_addr_next    = addr;
                        bus_rw_next      = rw;
                        bus_wr_data_next = wr_data;
                        state_next       = BUS_IF_STATE_REQ;
                    end
                end
            end
            BUS_IF_STATE_REQ: begin
                busy = 1'b1;
                if (bus.bus_grnt_ == ENABLE_) begin
                    bus_as_next = ENABLE_;
                    state_next  = BUS_IF_STATE_ACCESS;
`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
                    timer_clear = 1'b1;
`endif
                end
            end
            BUS_IF_STATE_ACCESS: begin
                // Strobe is a single-cycle pulse; ready is only looked at here.
                busy        = 1'b1;
                bus_as_next = DISABLE_;
                if (bus.bus_rdy_ == ENABLE_) begin
                    if (bus_rw_reg == READ)
                        rd_buf_next = bus.bus_rd_data;
                    bus_req_next = DISABLE_;
                    state_next   = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end
`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
                else begin
                    timer_count = 1'b1;
                    if (timer_expired) begin
                        rd_buf_next  = '0;
                        err_pulse    = 1'b1;
                        bus_req_next = DISABLE_;
                        state_next   = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    end
                end
`endif
            end
            BUS_IF_STATE_STALL: begin
                if (!stall)
                    state_next = BUS_IF_STATE_IDLE;
            end
            default: state_next = BUS_IF_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= BUS_IF_STATE_IDLE;
            bus_req_reg     <= DISABLE_;
            bus_as_reg      <= DISABLE_;
            bus_addr_reg    <= '0;
            bus_rw_reg      <= READ;
            bus_wr_data_reg <= '0;
            rd_buf_reg      <= '0;
            sel_spm_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bus_req_reg     <= bus_req_next;
            bus_as_reg      <= bus_as_next;
            bus_addr_reg    <= bus_addr_next;
            bus_rw_reg      <= bus_rw_next;
            bus_wr_data_reg <= bus_wr_data_next;
            rd_buf_reg      <= rd_buf_next;
            sel_spm_reg     <= sel_spm_next;
        end
    end

    assign rd_data         = sel_spm_reg ? spm_rd_data : rd_buf_reg;
    assign bus.bus_req_    = bus_req_reg;
    assign bus.bus_as_     = bus_as_reg;
    assign bus.bus_addr    = bus_addr_reg;
    assign bus.bus_rw      = bus_rw_reg;
    assign bus.bus_wr_data = bus_wr_data_reg;
    assign bus.bus_err     = err_pulse;
endmodule

// File: tb/tb_yutorina_bus_if.sv
// Directed bench for yutorina_bus_if: SPM read, external write/read,
// stall at completion, flush, reset mid-access and the ACCESS wait/timeout.
module tb_yutorina_bus_if;
    import yutorina_bus_if_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, flush, busy;
    word_addr_t addr;
    logic       as_, rw;
    word_data_t wr_data, rd_data;
    spm_addr_t  spm_addr;
    logic       spm_as_, spm_rw;
    word_data_t spm_wr_data, spm_rd_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int busy_cnt, as_cnt;

    always #5 clk = ~clk;

    yutorina_bus_if_if bus_i ();

    yutorina_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .busy        (busy),
        .addr        (addr),
        .as_         (as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_rd_data (spm_rd_data),
        .bus         (bus_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        as_   = DISABLE_;
        stall = 1'b0;
        flush = 1'b0;
        rw    = READ;
        addr  = '0;
        wr_data     = '0;
        spm_rd_data = '0;
        bus_i.bus_grnt_   = DISABLE_;
        bus_i.bus_rdy_    = DISABLE_;
        bus_i.bus_rd_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_busy",     busy,              0);
        check("rst_rd_data",  rd_data,           0);
        check("rst_spm_as",   spm_as_,           1);
        check("rst_bus_req",  bus_i.bus_req_,    1);
        check("rst_bus_as",   bus_i.bus_as_,     1);
        check("rst_bus_addr", bus_i.bus_addr,    0);
        check("rst_bus_rw",   bus_i.bus_rw,      READ);
        check("rst_bus_wdat", bus_i.bus_wr_data, 0);
        check("rst_bus_err",  bus_i.bus_err,     0);
        $display("[TB] txn reset done");
        cyc();

        // SPM read: address in N, data in N+1, then back to rd_buf.
        as_ = ENABLE_; rw = READ; addr = 30'h0800_0010;
        #1;
        check("spm_as",   spm_as_,  0);
        check("spm_addr", spm_addr, 12'h010);
        check("spm_rw",   spm_rw,   READ);
        check("spm_busy", busy,     0);
        cyc();
        as_ = DISABLE_; spm_rd_data = 32'hDEAD_BEEF;
        #1;
        check("spm_rd_data", rd_data, 32'hDEAD_BEEF);
        check("spm_busy_n1", busy,    0);
        cyc();
        #1;
        check("spm_sel_clear", rd_data, 0);
        $display("[TB] txn spm_read addr=%h data=%h", 30'h0800_0010, 32'hDEAD_BEEF);
        idle_in();
        cyc();

        // External write, grant after 2 waiting cycles, ready after 2 more.
        busy_cnt = 0; as_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0004; rw = WRITE; wr_data = 32'h1234_5678;
            bus_i.bus_grnt_ = (k == 3) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_  = (k == 6) ? ENABLE_ : DISABLE_;
            #1;
            if (busy) busy_cnt++;
            if (!bus_i.bus_as_) as_cnt++;
            if (k == 0) check("wr_spm_idle", spm_as_, 1);
            if (k == 1) check("wr_req_low", bus_i.bus_req_, 0);
            if (k == 4) begin
                check("wr_as_low",   bus_i.bus_as_,     0);
                check("wr_bus_addr", bus_i.bus_addr,    30'h0000_0004);
                check("wr_bus_rw",   bus_i.bus_rw,      WRITE);
                check("wr_bus_data", bus_i.bus_wr_data, 32'h1234_5678);
            end
            if (k == 7) check("wr_req_release", bus_i.bus_req_, 1);
            cyc();
        end
        check("wr_busy_cycles", busy_cnt, 7);
        check("wr_as_cycles",   as_cnt,   1);
        $display("[TB] txn ext_write addr=%h data=%h busy=%0d", 30'h4, 32'h1234_5678, busy_cnt);
        idle_in();

        // External read completing while stall is high.
        for (int k = 0; k < 7; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0100; rw = READ;
            bus_i.bus_grnt_   = (k == 1) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_    = (k == 2) ? ENABLE_ : DISABLE_;
            bus_i.bus_rd_data = (k == 2) ? 32'hCAFE_0001 : 32'h5555_5555;
            stall = (k >= 2 && k <= 4);
            #1;
            if (k <= 2) check("rd_busy_min", busy, 1);
            if (k == 3 || k == 4) begin
                check("rd_stall_busy", busy,    0);
                check("rd_stall_data", rd_data, 32'hCAFE_0001);
                check("rd_stall_req",  bus_i.bus_req_, 1);
            end
            if (k == 5) check("rd_unstall_busy", busy, 0);
            if (k == 6) check("rd_after_data", rd_data, 32'hCAFE_0001);
            cyc();
        end
        $display("[TB] txn ext_read_stall addr=%h data=%h", 30'h100, rd_data);
        idle_in();

        // Flush suppresses a new external request.
        as_ = ENABLE_; flush = 1'b1; addr = 30'h0000_0200; rw = READ;
        #1;
        check("flush_busy", busy, 0);
        cyc();
        as_ = DISABLE_; flush = 1'b0;
        #1;
        check("flush_req", bus_i.bus_req_, 1);
        check("flush_busy_n1", busy, 0);
        $display("[TB] txn flush_idle addr=%h", 30'h200);
        cyc();

        // Flush during ACCESS does not cancel the access.
        for (int k = 0; k < 5; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0300; rw = READ;
            bus_i.bus_grnt_   = (k == 1) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_    = (k == 3) ? ENABLE_ : DISABLE_;
            bus_i.bus_rd_data = (k == 3) ? 32'h0000_00A5 : 32'h0;
            flush = (k == 2 || k == 3);
            #1;
            if (k == 2 || k == 3) check("flacc_busy", busy, 1);
            if (k == 4) begin
                check("flacc_done_busy", busy,    0);
                check("flacc_rd_data",   rd_data, 32'h0000_00A5);
                check("flacc_req",       bus_i.bus_req_, 1);
            end
            cyc();
        end
        $display("[TB] txn flush_in_access addr=%h data=%h", 30'h300, rd_data);
        idle_in();

`ifdef YUTORINA_BUS_IF_TIMEOUT_EN
        // Ready never comes: abort on the 4th ACCESS cycle.
        for (int k = 0; k < 7; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0400; rw = READ;
            bus_i.bus_grnt_   = (k == 1) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_    = DISABLE_;
            bus_i.bus_rd_data = 32'hFFFF_FFFF;
            #1;
            if (k >= 2 && k <= 5) check("to_err", bus_i.bus_err, (k == 5) ? 1 : 0);
            if (k == 5) check("to_busy_last", busy, 1);
            if (k == 6) begin
                check("to_busy_drop", busy,    0);
                check("to_rd_data",   rd_data, 0);
                check("to_err_once",  bus_i.bus_err, 0);
                check("to_req",       bus_i.bus_req_, 1);
            end
            cyc();
        end
        $display("[TB] txn timeout addr=%h", 30'h400);
`else
        // Without the timeout, ACCESS waits as long as ready stays high.
        for (int k = 0; k < 10; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0400; rw = READ;
            bus_i.bus_grnt_   = (k == 1) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_    = (k == 8) ? ENABLE_ : DISABLE_;
            bus_i.bus_rd_data = (k == 8) ? 32'h0BAD_F00D : 32'h0;
            #1;
            if (k == 7) begin
                check("wait_busy", busy,          1);
                check("wait_err",  bus_i.bus_err, 0);
            end
            if (k == 9) begin
                check("wait_done_busy", busy,    0);
                check("wait_rd_data",   rd_data, 32'h0BAD_F00D);
            end
            cyc();
        end
        $display("[TB] txn long_wait addr=%h data=%h", 30'h400, rd_data);
`endif
        idle_in();

        // Reset while in ACCESS.
        for (int k = 0; k < 4; k++) begin
            as_ = (k == 0) ? ENABLE_ : DISABLE_;
            addr = 30'h0000_0500; rw = READ;
            bus_i.bus_grnt_ = (k == 1) ? ENABLE_ : DISABLE_;
            bus_i.bus_rdy_  = DISABLE_;
            reset = (k == 2);
            #1;
            if (k == 2) check("rstacc_as_pre", bus_i.bus_as_, 0);
            if (k == 3) begin
                check("rstacc_req",     bus_i.bus_req_, 1);
                check("rstacc_as",      bus_i.bus_as_,  1);
                check("rstacc_busy",    busy,           0);
                check("rstacc_rd_data", rd_data,        0);
            end
            cyc();
        end
        $display("[TB] txn reset_in_access addr=%h", 30'h500);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
